fpm_rr_scheduler: RTL and testbench

// - Shares one half-precision multiplier (fpm: clk, a[15:0], b[15:0] -> result[15:0]) among NUM_REQ vertex-shader lanes.
// - Round-robin arbiter issues at most one a*b operand pair per cycle into the multiplier.
// - Tracks each in-flight op by a one-hot tag pipeline and steers result back to the issuing lane.
// - Sits between the per-lane transform sequencers and the single fpm instance.

---
 rtl/fpm_rr_scheduler.sv | 162 ++++++++++++++++
 tb/tb_fpm_rr_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpm_rr_scheduler.sv
// fpm_rr_scheduler
//   Shares one half-precision multiplier (fpm) among NUM_REQ vertex-shader
//   lanes. A round-robin arbiter issues at most one operand pair per cycle.
//   A one-hot tag pipeline, as deep as the multiplier latency, follows each
//   op so that the result can be steered back to the lane that issued it.
//
// Parameters
//   NUM_REQ  number of requesting lanes (2..8)
//   FPM_LAT  fpm input-to-result latency in clk cycles (>=1)
//   DATA_W   operand/result width
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active low
//   req_valid   per-lane request pending
//   req_a/req_b per-lane operands, lane i at [i*DATA_W +: DATA_W]
//   req_ready   one-hot grant (combinational, 0 while in reset)
//   fpm_a/fpm_b operands of the granted lane to the multiplier (0 when idle)
//   fpm_result  multiplier result
//   rsp_valid   registered one-hot: rsp_data belongs to lane i
//   rsp_data    registered product, holds its value between responses
//   busy        any op in the tag pipeline or on the response register
//
// Build option
//   FPM_SCHED_PERF_EN: adds saturating 32-bit counters perf_issue_cnt
//   (granted cycles) and perf_stall_cnt (cycles with a valid lane left
//   ungranted). Without the macro the ports and counters do not exist.
module fpm_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int FPM_LAT = 1,
  parameter int DATA_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           fpm_a,
  output logic [DATA_W-1:0]           fpm_b,
  input  logic [DATA_W-1:0]           fpm_result,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy
`ifdef FPM_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_issue_cnt,
  output logic [31:0]                 perf_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam logic [PTR_W:0]   NREQ_EXT = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   rr_ptr_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic               grant_any_s;
  logic [PTR_W-1:0]   next_ptr_s;
  logic [NUM_REQ-1:0] tag_r [FPM_LAT];
  logic [NUM_REQ-1:0] tag_or_s;

  // Round-robin search: first valid lane starting at rr_ptr, wrapping.
  always_comb begin : rr_search
    logic [PTR_W:0] cand_v;
    logic           hit_v;
    grant_s     = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    cand_v      = '0;
    hit_v       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_v = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      cand_v = (cand_v >= NREQ_EXT) ? (cand_v - NREQ_EXT) : cand_v;
      // rst_n gating keeps req_ready at zero for the whole reset.
      hit_v  = rst_n & ~grant_any_s & req_valid[cand_v[PTR_W-1:0]];
      grant_s[cand_v[PTR_W-1:0]] = grant_s[cand_v[PTR_W-1:0]] | hit_v;
      grant_idx_s = hit_v ? cand_v[PTR_W-1:0] : grant_idx_s;
      grant_any_s = grant_any_s | hit_v;
    end
  end

  // Pointer moves to the lane after the winner.
  always_comb begin
    next_ptr_s = (grant_idx_s == LAST_IDX) ? '0 : (grant_idx_s + PTR_W'(1));
  end

  // Operand mux: AND-OR on the one-hot grant, so idle drives zero.
  always_comb begin
    fpm_a = '0;
    fpm_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fpm_a = fpm_a | (req_a[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
      fpm_b = fpm_b | (req_b[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
  end

  assign req_ready = grant_s;

  // Arbiter pointer, tag pipeline and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
      for (int j = 0; j < FPM_LAT; j++) begin
        tag_r[j] <= '0;
      end
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (grant_any_s) begin
        rr_ptr_r <= next_ptr_s;
      end
      tag_r[0] <= grant_s;
      for (int j = 1; j < FPM_LAT; j++) begin
        tag_r[j] <= tag_r[j-1];
      end
      // The last tag stage lines up with fpm_result for that op.
      rsp_valid <= tag_r[FPM_LAT-1];
      if (|tag_r[FPM_LAT-1]) begin
        rsp_data <= fpm_result;
      end
    end
  end

  // busy: anything still travelling through tags or the response register.
  always_comb begin
    tag_or_s = '0;
    for (int j = 0; j < FPM_LAT; j++) begin
      tag_or_s = tag_or_s | tag_r[j];
    end
    busy = (|tag_or_s) | (|rsp_valid);
  end

`ifdef FPM_SCHED_PERF_EN
  logic stall_s;

  // A stall cycle: some lane is asking but did not get the multiplier.
  always_comb begin
    stall_s = |(req_valid & ~grant_s);
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issue_cnt <= 32'h0000_0000;
      perf_stall_cnt <= 32'h0000_0000;
    end else begin
      if (grant_any_s && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
      if (stall_s && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fpm_rr_scheduler.sv
// tb_fpm_rr_scheduler
//   Directed self-checking bench for fpm_rr_scheduler (NUM_REQ=4,
//   FPM_LAT=1). A one-cycle stand-in multiplier returns known half-precision
//   products for the directed operand pairs and a simple a+b for the rest.
//   Perf counter checks are compiled when FPM_SCHED_PERF_EN is defined.
module tb_fpm_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int FPM_LAT = 1;
  localparam int DATA_W  = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         fpm_a;
  logic [DATA_W-1:0]         fpm_b;
  logic [DATA_W-1:0]         fpm_result;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;
`ifdef FPM_SCHED_PERF_EN
  logic [31:0]               perf_issue_cnt;
  logic [31:0]               perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] lane_a [NUM_REQ];
  logic [15:0] lane_b [NUM_REQ];

  always #5 clk = ~clk;

  fpm_rr_scheduler #(
    .NUM_REQ(NUM_REQ),
    .FPM_LAT(FPM_LAT),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .fpm_a     (fpm_a),
    .fpm_b     (fpm_b),
    .fpm_result(fpm_result),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef FPM_SCHED_PERF_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Stand-in multiplier: hand-computed half-precision products.
  function automatic logic [15:0] fpm_fn(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'hBC33_3C00: fpm_fn = 16'hBC33;  // -1.0498 * 1.0
      32'h5620_5600: fpm_fn = 16'h7098;  // 98 * 96 = 9408
      32'hD160_54C0: fpm_fn = 16'hEA62;  // -43 * 76 = -3268
      32'h3C00_0000: fpm_fn = 16'h0000;  // 1.0 * 0
      32'h0000_0000: fpm_fn = 16'h0000;
      default:       fpm_fn = a + b;
    endcase
  endfunction

  // One-cycle multiplier latency.
  always @(posedge clk) fpm_result <= fpm_fn(fpm_a, fpm_b);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issue a single op from one lane and follow it to its response.
  task automatic single_op(input int lane, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_d);
    logic [3:0] oh;
    oh = 4'b0001 << lane;
    set_lane(lane, a, b);
    req_valid = oh;
    #1;
    check_val("single_ready", 32'(req_ready), 32'(oh));
    check_val("single_fpm_a", 32'(fpm_a), 32'(a));
    check_val("single_fpm_b", 32'(fpm_b), 32'(b));
    tick();
    req_valid = '0;
    #1;
    check_val("single_inflight_rsp", 32'(rsp_valid), 32'h0);
    check_val("single_busy", 32'(busy), 32'h1);
    tick();
    check_val("single_rsp_valid", 32'(rsp_valid), 32'(oh));
    check_val("single_rsp_data", 32'(rsp_data), 32'(exp_d));
    tick();
    check_val("single_rsp_drop", 32'(rsp_valid), 32'h0);
    check_val("single_rsp_hold", 32'(rsp_data), 32'(exp_d));
    check_val("single_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_a[i] = 16'h4000 + 16'(i) * 16'h0111;
      lane_b[i] = 16'h4400 + 16'(i) * 16'h0030;
      set_lane(i, lane_a[i], lane_b[i]);
    end
    // Reset with every lane asking: nothing may be granted.
    req_valid = 4'hF;
    tick();
    tick();
    check_val("rst_ready", 32'(req_ready), 32'h0);
    check_val("rst_fpm_a", 32'(fpm_a), 32'h0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_val("rst_rsp_data", 32'(rsp_data), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
`ifdef FPM_SCHED_PERF_EN
    check_val("rst_perf_issue", perf_issue_cnt, 32'h0);
    check_val("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single ops: ptr 0 -> lane0, ptr 1 -> lane2, ptr 3 -> lane1 (wraps).
    single_op(0, 16'hBC33, 16'h3C00, 16'hBC33);
    single_op(2, 16'h5620, 16'h5600, 16'h7098);
    single_op(1, 16'hD160, 16'h54C0, 16'hEA62);

    // All lanes valid for 8 cycles from rr_ptr=0.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, lane_a[i], lane_b[i]);
    for (int k = 0; k < 10; k++) begin
      logic [3:0] exp_rdy;
      logic [3:0] exp_rsp;
      int         rl;
      req_valid = (k < 8) ? 4'hF : 4'h0;
      exp_rdy   = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      #1;
      check_val($sformatf("all_ready_%0d", k), 32'(req_ready), 32'(exp_rdy));
      if (k >= 2) begin
        rl      = (k - 2) % 4;
        exp_rsp = 4'b0001 << rl;
        check_val($sformatf("all_rsp_valid_%0d", k), 32'(rsp_valid), 32'(exp_rsp));
        check_val($sformatf("all_rsp_data_%0d", k), 32'(rsp_data),
                  32'(fpm_fn(lane_a[rl], lane_b[rl])));
      end else begin
        check_val($sformatf("all_rsp_none_%0d", k), 32'(rsp_valid), 32'h0);
      end
      tick();
    end
    check_val("all_drained", 32'(rsp_valid), 32'h0);
    check_val("all_busy", 32'(busy), 32'h0);
`ifdef FPM_SCHED_PERF_EN
    check_val("perf_issue", perf_issue_cnt, 32'd8);
    check_val("perf_stall", perf_stall_cnt, 32'd8);
`endif

    // Lane3 back-to-back: zero results both cycles, no bubble.
    set_lane(3, 16'h3C00, 16'h0000);
    req_valid = 4'b1000;
    #1;
    check_val("b2b_ready0", 32'(req_ready), 32'h8);
    tick();
    set_lane(3, 16'h0000, 16'h0000);
    #1;
    check_val("b2b_ready1", 32'(req_ready), 32'h8);
    check_val("b2b_fpm_a", 32'(fpm_a), 32'h0);
    tick();
    req_valid = '0;
    #1;
    check_val("b2b_rsp0_valid", 32'(rsp_valid), 32'h8);
    check_val("b2b_rsp0_data", 32'(rsp_data), 32'h0);
    tick();
    check_val("b2b_rsp1_valid", 32'(rsp_valid), 32'h8);
    check_val("b2b_rsp1_data", 32'(rsp_data), 32'h0);
    tick();
    check_val("b2b_done", 32'(rsp_valid), 32'h0);

    // Reset one cycle before the lane1 result arrives.
    set_lane(1, 16'hD160, 16'h54C0);
    req_valid = 4'b0010;
    #1;
    check_val("mid_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0110;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    req_valid = '0;
    #1;
    check_val("mid_rsp0", 32'(rsp_valid), 32'h0);
    check_val("mid_busy", 32'(busy), 32'h0);
    tick();
    check_val("mid_rsp1", 32'(rsp_valid), 32'h0);
    set_lane(2, 16'h5620, 16'h5600);
    req_valid = 4'b0110;
    #1;
    check_val("mid_regrant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    tick();

    // Wrap: lane2 alone sets rr_ptr=3, then lanes 0 and 3 alternate.
    req_valid = 4'b0100;
    #1;
    check_val("wrap_pre", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1001;
    #1;
    check_val("wrap_g3", 32'(req_ready), 32'h8);
    tick();
    check_val("wrap_g0", 32'(req_ready), 32'h1);
    tick();
    check_val("wrap_g3b", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    check_val("end_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
